mat_operand_seq: RTL and testbench
==================================

// Module: mat_operand_seq
// PURPOSE
//  Upstream operand sequencer for the 4-element dot-product stage (mat_mult). Loads a
//  4x4 A matrix and a 4x4 B matrix over a serial valid/ready stream into local registers.
//  It then issues all 16 (row i of A, column j of B) vector pairs, one per clock, to the
//  A0x_80/B0x_80 inputs of mat_mult. It tags each result with its (i,j) index.
// PARAMETERS
//  WIDTH_A_80  9  bit width of A elements (signed fractional, matches mat_mult)
//  WIDTH_B_80  8  bit width of B elements (signed fractional, matches mat_mult)
// PORTS
//  clk_80        in   1            clock, rising edge
//  rst_80        in   1            reset, asynchronous, active-low
//  ld_valid_80   in   1            load word valid
//  ld_ready_80   out  1            load word accepted when ld_valid_80 & ld_ready_80
//  ld_data_80    in   WIDTH_A_80   load word; B words use ld_data_80[WIDTH_B_80-1:0]
//  A00_80..A03_80 out WIDTH_A_80   A(i,0..3) to mat_mult, registered
//  B00_80..B03_80 out WIDTH_B_80   B(0..3,j) to mat_mult, registered
//  vec_valid_80  out  1            A0x/B0x carry a live operand pair this cycle
//  vec_row_80    out  2            i of current operand pair
//  vec_col_80    out  2            j of current operand pair
//  res_valid_80  out  1            mat_mult AB00_80 holds C(res_row,res_col) this cycle
//  res_row_80    out  2            i of the result currently on AB00_80
//  res_col_80    out  2            j of the result currently on AB00_80
//  done_80       out  1            one-cycle pulse with the 16th res_valid_80
// BEHAVIOUR
//  Reset (rst_80=0): all outputs 0; state LOAD_A; counters 0; element storage 0.
//  FSM LOAD_A -> LOAD_B -> ISSUE -> LOAD_A.
//  LOAD_A: ld_ready_80=1. Each accepted word is stored row-major at A[cnt>>2][cnt&3], then cnt++.
//   The 16th accept (cnt=15) clears cnt and moves to LOAD_B.
//  LOAD_B: same scheme, storing B[cnt>>2][cnt&3] <= ld_data_80[WIDTH_B_80-1:0].
//   The 16th accept moves to ISSUE.
//  ISSUE: ld_ready_80=0. A 4-bit issue counter k runs 0..15, with i=k[3:2] and j=k[1:0].
//   Each edge registers A0x_80<=A[i][x], B0x_80<=B[x][j], vec_row/col<=i/j, vec_valid_80<=1.
//   vec_valid_80 rises on the first edge after the last B accept. It stays high for exactly
//   16 consecutive cycles with no gaps and no backpressure, because mat_mult cannot stall.
//   The edge after k=15 returns to LOAD_A. ld_ready_80 is 1 again while the last result
//   is still in flight.
//  Idle operands: whenever vec_valid_80=0, A0x/B0x/vec_row/vec_col are driven 0.
//  Result tagging: mat_mult has 1 register stage. res_valid/res_row/res_col equal
//   vec_valid/vec_row/vec_col delayed by exactly 1 clock.
//   done_80 = res_valid_80 & res_row_80==3 & res_col_80==3.
//  ld_valid_80 gaps: cnt holds and storage is unchanged. ld_valid_80 while ld_ready_80=0:
//   the word is ignored.
//  No arithmetic is done here. Elements pass bit-exact. Illegal-value correction
//   (100..0 -> 100..1) stays in mat_mult and is not duplicated here.
//  Reset mid-operation: all outputs go to 0 asynchronously, including vec_valid and
//   res_valid, and the FSM restarts in LOAD_A. Any partial matrix is discarded.
// CONFIGURATION
//  MAT_SEQ_KEEP_B_EN defined: this adds the input port ld_keep_b_80 (1 bit).
//   It is sampled on the edge accepting the 16th A word. If it is 1, the FSM goes
//   LOAD_A -> ISSUE, skips LOAD_B and reuses the stored B.
//   If it is 0, or the macro is undefined, LOAD_B always follows LOAD_A.
//  MAT_SEQ_KEEP_B_EN undefined: the ld_keep_b_80 port does not exist.
// TESTING
//  1 Load A=all 9'h040, B=all 8'h20, ld_valid_80 held 1
//    -> ld_ready_80 is 1 for 32 cycles, then vec_valid_80 is 1 for 16 cycles with
//       A0x=9'h040, B0x=8'h20 and (row,col) stepping (0,0)..(3,3).
//    -> res_valid_80 follows 1 cycle later; done_80 pulses once with res (3,3).
//  2 A(i,k)=4i+k, B(k,j)=4k+j
//    -> at vec (1,2): A00..A03 = 4,5,6,7 and B00..B03 = 2,6,10,14.
//    -> at vec (3,0): A00..A03 = 12..15 and B00..B03 = 0,4,8,12.
//  3 ld_valid_80 toggled 1,0,1,0 during load
//    -> exactly 32 accepts are needed; stored matrices are identical to test 2; no skipped index.
//  4 ld_valid_80=1 throughout ISSUE with data 9'h1FF
//    -> ld_ready_80=0 for all 16 cycles; the next issue pass shows the original matrices.
//  5 rst_80 low at the 7th vec_valid cycle
//    -> all outputs are 0 immediately; after release ld_ready_80=1 in LOAD_A; cnt restarts at A(0,0).
//  6 MAT_SEQ_KEEP_B_EN defined: run test 2, then reload A=all 0 with ld_keep_b_80=1
//    -> ISSUE starts after 16 accepts, and B0x repeats the test-2 columns.

Source files
------------

// File: rtl/mat_operand_seq_if.sv
// mat_operand_seq_if: load stream, operand and result-tag bundle between mat_operand_seq and its neighbours
interface mat_operand_seq_if #(
  parameter int WIDTH_A_80 = 9,
  parameter int WIDTH_B_80 = 8
);
  logic                  ld_valid_80;
  logic                  ld_ready_80;
  logic [WIDTH_A_80-1:0] ld_data_80;
  logic [WIDTH_A_80-1:0] A00_80, A01_80, A02_80, A03_80;
  logic [WIDTH_B_80-1:0] B00_80, B01_80, B02_80, B03_80;
  logic                  vec_valid_80;
  logic [1:0]            vec_row_80, vec_col_80;
  logic                  res_valid_80;
  logic [1:0]            res_row_80, res_col_80;
  logic                  done_80;
  modport master (
    output ld_valid_80, ld_data_80,
    input  ld_ready_80, A00_80, A01_80, A02_80, A03_80, B00_80, B01_80, B02_80, B03_80,
    input  vec_valid_80, vec_row_80, vec_col_80, res_valid_80, res_row_80, res_col_80, done_80
  );
  modport slave (
    input  ld_valid_80, ld_data_80,
    output ld_ready_80, A00_80, A01_80, A02_80, A03_80, B00_80, B01_80, B02_80, B03_80,
    output vec_valid_80, vec_row_80, vec_col_80, res_valid_80, res_row_80, res_col_80, done_80
  );
endinterface

// File: rtl/mat_operand_seq.sv
// mat_operand_seq: loads 4x4 A/B serially, issues 16 (i,j) operand pairs to mat_mult; MAT_SEQ_KEEP_B_EN adds ld_keep_b_80 to reuse B
module mat_operand_seq #(
  parameter int WIDTH_A_80 = 9,
  parameter int WIDTH_B_80 = 8
) (
  input  logic clk_80,
  input  logic rst_80,
`ifdef MAT_SEQ_KEEP_B_EN
  input  logic ld_keep_b_80,
`endif
  mat_operand_seq_if.slave bus
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, ISSUE} state_t;
  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  ld_ready, accept, keep_b, issuing;
  logic [WIDTH_A_80-1:0] a_mem [4][4];
  logic [WIDTH_B_80-1:0] b_mem [4][4];
  logic [WIDTH_A_80-1:0] a_op [4];
  logic [WIDTH_B_80-1:0] b_op [4];
  logic                  vec_valid, res_valid, done;
  logic [1:0]            vec_row, vec_col, res_row, res_col;
`ifdef MAT_SEQ_KEEP_B_EN
  assign keep_b = ld_keep_b_80;
`else
  assign keep_b = 1'b0;
`endif
  assign accept  = bus.ld_valid_80 & ld_ready;
  assign issuing = state == ISSUE;
  always_comb begin
    state_nxt = state;
    if (state == LOAD_A && accept && cnt == 4'd15) state_nxt = keep_b ? ISSUE : LOAD_B;
    else if (state == LOAD_B && accept && cnt == 4'd15) state_nxt = ISSUE;
    else if (issuing && cnt == 4'd15) state_nxt = LOAD_A;
  end
  always_ff @(posedge clk_80 or negedge rst_80)
    if (!rst_80) state <= LOAD_A;
    else state <= state_nxt;
  // one counter serves as the load index and, in ISSUE, as k = {i,j}; it wraps 15 -> 0 on every phase exit
  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      cnt       <= '0;
      ld_ready  <= 1'b0;
      vec_valid <= 1'b0;
      vec_row   <= '0;
      vec_col   <= '0;
      res_valid <= 1'b0;
      res_row   <= '0;
      res_col   <= '0;
      done      <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        a_op[r] <= '0;
        b_op[r] <= '0;
        for (int c = 0; c < 4; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
    end else begin
      ld_ready <= state_nxt != ISSUE;
      if (issuing || accept) cnt <= cnt + 4'd1;
      if (accept && state == LOAD_A) a_mem[cnt[3:2]][cnt[1:0]] <= bus.ld_data_80;
      if (accept && state == LOAD_B) b_mem[cnt[3:2]][cnt[1:0]] <= bus.ld_data_80[WIDTH_B_80-1:0];
      vec_valid <= issuing;
      vec_row   <= issuing ? cnt[3:2] : 2'd0;
      vec_col   <= issuing ? cnt[1:0] : 2'd0;
      for (int x = 0; x < 4; x++) begin
        a_op[x] <= issuing ? a_mem[cnt[3:2]][x] : '0;
        b_op[x] <= issuing ? b_mem[x][cnt[1:0]] : '0;
      end
      res_valid <= vec_valid;
      res_row   <= vec_row;
      res_col   <= vec_col;
      done      <= vec_valid && vec_row == 2'd3 && vec_col == 2'd3;
    end
  end
  assign bus.ld_ready_80  = ld_ready;
  assign bus.A00_80       = a_op[0];
  assign bus.A01_80       = a_op[1];
  assign bus.A02_80       = a_op[2];
  assign bus.A03_80       = a_op[3];
  assign bus.B00_80       = b_op[0];
  assign bus.B01_80       = b_op[1];
  assign bus.B02_80       = b_op[2];
  assign bus.B03_80       = b_op[3];
  assign bus.vec_valid_80 = vec_valid;
  assign bus.vec_row_80   = vec_row;
  assign bus.vec_col_80   = vec_col;
  assign bus.res_valid_80 = res_valid;
  assign bus.res_row_80   = res_row;
  assign bus.res_col_80   = res_col;
  assign bus.done_80      = done;
endmodule

// File: tb/tb_mat_operand_seq.sv
// tb_mat_operand_seq: random-gap loads and issue passes checked against a matrix-level reference model
module tb_mat_operand_seq;
  logic clk_80 = 1'b0;
  logic rst_80 = 1'b0;
`ifdef MAT_SEQ_KEEP_B_EN
  logic ld_keep_b_80 = 1'b0;
`endif
  int vecs = 0;
  int errs = 0;
  logic [8:0] ma [4][4];
  logic [7:0] mb [4][4];
  mat_operand_seq_if #(.WIDTH_A_80(9), .WIDTH_B_80(8)) bus ();
  mat_operand_seq #(.WIDTH_A_80(9), .WIDTH_B_80(8)) dut (
    .clk_80(clk_80),
    .rst_80(rst_80),
`ifdef MAT_SEQ_KEEP_B_EN
    .ld_keep_b_80(ld_keep_b_80),
`endif
    .bus(bus)
  );
  always #5 clk_80 = ~clk_80;
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [35:0] a_row(int i);
    return {ma[i][0], ma[i][1], ma[i][2], ma[i][3]};
  endfunction
  function automatic logic [31:0] b_col(int j);
    return {mb[0][j], mb[1][j], mb[2][j], mb[3][j]};
  endfunction
  function automatic logic [95:0] all_outs();
    return {bus.ld_ready_80, bus.vec_valid_80, bus.res_valid_80, bus.done_80,
            bus.vec_row_80, bus.vec_col_80, bus.res_row_80, bus.res_col_80,
            bus.A00_80, bus.A01_80, bus.A02_80, bus.A03_80,
            bus.B00_80, bus.B01_80, bus.B02_80, bus.B03_80};
  endfunction
  // mode 0: valid held, 1: toggled 1,0,1,0, 2: random gaps
  task automatic load(input bit do_b, input int mode, input bit keep);
    int n = 0;
    int cyc = 0;
    int total = do_b ? 32 : 16;
    logic v;
    while (n < total && cyc < 400) begin
      @(negedge clk_80);
      cyc++;
      chk("ld_ready_load", bus.ld_ready_80, 1'b1);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom);
      bus.ld_valid_80 = v;
`ifdef MAT_SEQ_KEEP_B_EN
      ld_keep_b_80 = keep;
`endif
      if (!v) bus.ld_data_80 = 9'($urandom);
      else if (n < 16) bus.ld_data_80 = ma[n / 4][n % 4];
      else bus.ld_data_80 = {1'($urandom), mb[(n - 16) / 4][(n - 16) % 4]};
      n += int'(v);
    end
    if (n < total) chk("load_timeout", 96'(n), 96'(total));
  endtask
  // t counts negedges after the last load accept; rst_at < 0 means no reset
  task automatic issue(input int rst_at);
    int k, r;
    logic ev, er;
    for (int t = 0; t <= 18; t++) begin
      @(negedge clk_80);
      k  = t - 1;
      r  = t - 2;
      ev = t >= 1 && t <= 16;
      er = t >= 2 && t <= 17;
      chk("vec_valid", bus.vec_valid_80, ev);
      chk("vec_tag", {bus.vec_row_80, bus.vec_col_80}, ev ? 4'(k) : 4'd0);
      chk("A0x", {bus.A00_80, bus.A01_80, bus.A02_80, bus.A03_80}, ev ? a_row(k / 4) : 36'd0);
      chk("B0x", {bus.B00_80, bus.B01_80, bus.B02_80, bus.B03_80}, ev ? b_col(k % 4) : 32'd0);
      chk("res_valid", bus.res_valid_80, er);
      chk("res_tag", {bus.res_row_80, bus.res_col_80}, er ? 4'(r) : 4'd0);
      chk("done", bus.done_80, t == 17);
      chk("ld_ready_issue", bus.ld_ready_80, t >= 16);
      if (t == rst_at) begin
        rst_80 = 1'b0;
        bus.ld_valid_80 = 1'b0;
        #1;
        chk("mid_reset_outs", all_outs(), 96'd0);
        @(negedge clk_80);
        rst_80 = 1'b1;
        return;
      end
      bus.ld_valid_80 = t < 16 ? 1'($urandom) : 1'b0;
      bus.ld_data_80  = 9'h1FF;
    end
  endtask
  task automatic rand_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 9'($urandom);
        mb[i][j] = 8'($urandom);
      end
  endtask
  task automatic index_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 9'(4 * i + j);
        mb[i][j] = 8'(4 * i + j);
      end
  endtask
  initial begin
    bus.ld_valid_80 = 1'b0;
    bus.ld_data_80  = '0;
    #2;
    chk("reset_outs", all_outs(), 96'd0);
    @(negedge clk_80);
    @(negedge clk_80);
    rst_80 = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 9'h040;
        mb[i][j] = 8'h20;
      end
    load(1'b1, 0, 1'b0);
    issue(-1);
    index_mats();
    load(1'b1, 0, 1'b0);
    issue(-1);
    chk("t2_a_row1", a_row(1), {9'd4, 9'd5, 9'd6, 9'd7});
    chk("t2_b_col2", b_col(2), {8'd2, 8'd6, 8'd10, 8'd14});
    load(1'b1, 1, 1'b0);
    issue(-1);
    rand_mats();
    load(1'b1, 2, 1'b0);
    issue(7);
    rand_mats();
    load(1'b1, 2, 1'b0);
    issue(-1);
    repeat (4) begin
      rand_mats();
      load(1'b1, 2, 1'b0);
      issue(-1);
    end
`ifdef MAT_SEQ_KEEP_B_EN
    index_mats();
    load(1'b1, 0, 1'b0);
    issue(-1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ma[i][j] = 9'd0;
    load(1'b0, 0, 1'b1);
    ld_keep_b_80 = 1'b0;
    issue(-1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
